// File: rtl/conv_sequencer_pkg.sv
// conv_sequencer_pkg
//   Shared definitions for the convolution sequencer:
//   - FSM state encoding (IDLE..DONE)
//   - clog2 helper for sizing counters from parameters
//   - output-count helper and the default YLEN
package conv_sequencer_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_X = 3'd1;
  localparam logic [2:0] LOAD_H = 3'd2;
  localparam logic [2:0] SETUP  = 3'd3;
  localparam logic [2:0] MAC    = 3'd4;
  localparam logic [2:0] EMIT   = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  localparam int XLEN_DEFAULT = 8;
  localparam int HLEN_DEFAULT = 3;

  // Ceiling log2; usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Number of outputs of a full linear convolution.
  function automatic int calc_ylen(input int xlen, input int hlen);
    return xlen + hlen - 1;
  endfunction

  localparam int YLEN = calc_ylen(XLEN_DEFAULT, HLEN_DEFAULT);

endpackage

// File: rtl/conv_tap_range.sv
// conv_tap_range
//   Combinational map from output index n to the range of kernel taps k
//   that touch real samples: kmin = max(0, n-XLEN+1), kmax = min(n, HLEN-1).
// Ports:
//   n     in  CW  output index
//   kmin  out CW  first valid tap
//   kmax  out CW  last valid tap
module conv_tap_range
  import conv_sequencer_pkg::*;
#(
  parameter int XLEN = 8,
  parameter int HLEN = 3,
  parameter int CW   = clog2(calc_ylen(XLEN, HLEN) + 1)
) (
  input  logic [CW-1:0] n,
  output logic [CW-1:0] kmin,
  output logic [CW-1:0] kmax
);

  localparam logic [CW-1:0] XM1 = CW'(XLEN - 1);
  localparam logic [CW-1:0] HM1 = CW'(HLEN - 1);

  // Compare first so the unsigned subtraction never underflows.
  always_comb begin
    kmin = (n > XM1) ? (n - XM1) : '0;
    kmax = (n < HM1) ? n : HM1;
  end

endmodule

// File: rtl/conv_sequencer.sv
// conv_sequencer
//   Control FSM for a single-multiplier convolution engine. Loads XLEN
//   samples into the x RAM and HLEN taps into the h RAM from one stream,
//   then for each n issues only the in-range taps (one per cycle) to an
//   external MAC and presents y[n] with a valid/ready handshake.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             begin a job (IDLE only)
//   in_valid/in_ready input stream handshake (data goes straight to RAMs)
//   ram_clr           pulse clearing both RAM write pointers
//   x_wr, h_wr        RAM write strobes
//   x_rd, h_rd        RAM read enables
//   x_adr, h_adr      RAM read addresses (n-k, k)
//   mac_clr, mac_en   accumulator clear / accumulate
//   y_valid, y_ready  output handshake; y_idx is the current n
//   busy, done        job status; done pulses once per job
module conv_sequencer
  import conv_sequencer_pkg::*;
#(
  parameter  int M    = 4,
  parameter  int XLEN = 8,
  parameter  int HLEN = 3,
  localparam int NOUT = calc_ylen(XLEN, HLEN),
  localparam int CW   = clog2(NOUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          ram_clr,
  output logic          x_wr,
  output logic          h_wr,
  output logic          x_rd,
  output logic          h_rd,
  output logic [M-1:0]  x_adr,
  output logic [M-1:0]  h_adr,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          y_valid,
  input  logic          y_ready,
  output logic [CW-1:0] y_idx,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] XM1 = CW'(XLEN - 1);
  localparam logic [CW-1:0] HM1 = CW'(HLEN - 1);
  localparam logic [CW-1:0] YM1 = CW'(NOUT - 1);

  logic [2:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [CW-1:0] n_reg, n_next;
  logic [CW-1:0] k_reg, k_next;
  logic [CW-1:0] kmin, kmax;

  conv_tap_range #(
    .XLEN (XLEN),
    .HLEN (HLEN),
    .CW   (CW)
  ) u_tap_range (
    .n    (n_reg),
    .kmin (kmin),
    .kmax (kmax)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      n_reg     <= '0;
      k_reg     <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      n_reg     <= n_next;
      k_reg     <= k_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    n_next     = n_reg;
    k_next     = k_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = LOAD_X;
          cnt_next   = '0;
        end
      end
      LOAD_X: begin
        if (in_valid) begin
          if (cnt_reg == XM1) begin
            state_next = LOAD_H;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      LOAD_H: begin
        if (in_valid) begin
          if (cnt_reg == HM1) begin
            state_next = SETUP;
            cnt_next   = '0;
            n_next     = '0;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      SETUP: begin
        // Start at the first tap that overlaps a real sample.
        k_next     = kmin;
        state_next = MAC;
      end
      MAC: begin
        if (k_reg == kmax) state_next = EMIT;
        else               k_next     = k_reg + CW'(1);
      end
      EMIT: begin
        if (y_ready) begin
          if (n_reg == YM1) begin
            state_next = DONE;
          end else begin
            n_next     = n_reg + CW'(1);
            state_next = SETUP;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        n_next     = '0;
        k_next     = '0;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode from state only (plus the start/in_valid pass-through),
  // so an asynchronous reset drives them all to 0 immediately.
  always_comb begin
    in_ready = (state_reg == LOAD_X) || (state_reg == LOAD_H);
    ram_clr  = (state_reg == IDLE) && start && !rst;
    x_wr     = (state_reg == LOAD_X) && in_valid;
    h_wr     = (state_reg == LOAD_H) && in_valid;
    x_rd     = (state_reg == MAC);
    h_rd     = (state_reg == MAC);
    mac_en   = (state_reg == MAC);
    mac_clr  = (state_reg == SETUP);
    x_adr    = (state_reg == MAC) ? M'(n_reg - k_reg) : '0;
    h_adr    = (state_reg == MAC) ? M'(k_reg) : '0;
    y_valid  = (state_reg == EMIT);
    y_idx    = (state_reg == EMIT) ? n_reg : '0;
    busy     = (state_reg != IDLE);
    done     = (state_reg == DONE);
  end

endmodule
